checksum_accum: RTL



---
 rtl/checksum_accum_if.sv | 33 +++
 rtl/checksum_accum.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/checksum_accum_if.sv
// -----------------------------------------------------------------------------
// checksum_accum_if
// Bundles the beat-input and result-output handshakes of checksum_accum.
//   s_valid/s_ready/s_data/s_keep/s_last : packet beats into the accumulator
//   m_valid/m_ready/m_data/m_words/m_sat : folded-sum result to the fold block
// Modports:
//   slave  - the accumulator's view (consumes beats, produces the result)
//   master - the environment's view (produces beats, consumes the result)
// -----------------------------------------------------------------------------
interface checksum_accum_if #(
    parameter int CNT_W = 16
) ();
    logic             s_valid;
    logic             s_ready;
    logic [31:0]      s_data;
    logic [3:0]       s_keep;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [31:0]      m_data;
    logic [CNT_W-1:0] m_words;
    logic             m_sat;

    modport slave (
        input  s_valid, s_data, s_keep, s_last, m_ready,
        output s_ready, m_valid, m_data, m_words, m_sat
    );

    modport master (
        output s_valid, s_data, s_keep, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_words, m_sat
    );
endinterface

// File: rtl/checksum_accum.sv
// -----------------------------------------------------------------------------
// checksum_accum
// Accumulates a packet of 32-bit beats into two independent 16-bit
// end-around-carry (one's-complement) sums, one over the upper halves and one
// over the lower halves. On the last beat the pair {sum_hi, sum_lo} is
// registered onto m_data together with a saturating beat count, and held
// until the downstream fold block accepts it.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus    - checksum_accum_if.slave: s_valid/s_ready/s_data/s_keep/s_last in,
//            m_valid/m_ready/m_data/m_words/m_sat out
// -----------------------------------------------------------------------------
module checksum_accum #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    checksum_accum_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // One's-complement add: the carry out of bit 15 is wrapped back into bit 0.
    // A second carry is impossible since t[15:0] <= 16'hFFFE whenever t[16]=1.
    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] t;
        t = {1'b0, a} + {1'b0, b};
        return t[15:0] + {15'd0, t[16]};
    endfunction

    // Zero every byte whose keep bit is clear; keep[3] qualifies data[31:24].
    function automatic logic [31:0] mask_bytes(input logic [31:0] data, input logic [3:0] keep);
        logic [31:0] m;
        m = 32'd0;
        for (int b = 0; b < 4; b++) begin
            if (keep[b]) begin
                m[b*8 +: 8] = data[b*8 +: 8];
            end else begin
                m[b*8 +: 8] = 8'd0;
            end
        end
        return m;
    endfunction

    state_t           state_q,   state_d;
    logic             s_ready_q, s_ready_d;
    logic             m_valid_q, m_valid_d;
    logic [15:0]      acc_hi_q,  acc_hi_d;
    logic [15:0]      acc_lo_q,  acc_lo_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             sat_q,     sat_d;
    logic [31:0]      m_data_q,  m_data_d;
    logic [CNT_W-1:0] m_words_q, m_words_d;
    logic             m_sat_q,   m_sat_d;

    logic             beat_s;
    logic [31:0]      masked_s;
    logic [15:0]      sum_hi_s;
    logic [15:0]      sum_lo_s;
    logic [CNT_W-1:0] count_inc_s;
    logic             sat_inc_s;

    // Next-state, accumulator, counter and result-register logic.
    always_comb begin
        state_d   = state_q;
        s_ready_d = s_ready_q;
        m_valid_d = m_valid_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        count_d   = count_q;
        sat_d     = sat_q;
        m_data_d  = m_data_q;
        m_words_d = m_words_q;
        m_sat_d   = m_sat_q;

        // s_ready_q is only high in ACCUM, so this is the transfer condition.
        beat_s   = bus.s_valid & s_ready_q;
        masked_s = mask_bytes(bus.s_data, bus.s_keep);
        sum_hi_s = oc_add(acc_hi_q, masked_s[31:16]);
        sum_lo_s = oc_add(acc_lo_q, masked_s[15:0]);

        // The counter sticks at its maximum; a beat arriving there means the
        // true count is no longer representable, which is what sat flags.
        if (count_q == CNT_MAX) begin
            count_inc_s = count_q;
            sat_inc_s   = 1'b1;
        end else begin
            count_inc_s = count_q + CNT_ONE;
            sat_inc_s   = sat_q;
        end

        case (state_q)
            ST_ACCUM: begin
                if (beat_s) begin
                    if (bus.s_last) begin
                        m_data_d  = {sum_hi_s, sum_lo_s};
                        m_words_d = count_inc_s;
                        m_sat_d   = sat_inc_s;
                        acc_hi_d  = 16'd0;
                        acc_lo_d  = 16'd0;
                        count_d   = CNT_ZERO;
                        sat_d     = 1'b0;
                        state_d   = ST_HOLD;
                        s_ready_d = 1'b0;
                        m_valid_d = 1'b1;
                    end else begin
                        acc_hi_d  = sum_hi_s;
                        acc_lo_d  = sum_lo_s;
                        count_d   = count_inc_s;
                        sat_d     = sat_inc_s;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                // Result is consumed here; the next beat can only be taken on
                // the following edge, giving the one-cycle inter-packet gap.
                if (bus.m_ready) begin
                    state_d   = ST_ACCUM;
                    s_ready_d = 1'b1;
                    m_valid_d = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d   = ST_ACCUM;
                s_ready_d = 1'b1;
                m_valid_d = 1'b0;
                acc_hi_d  = 16'd0;
                acc_lo_d  = 16'd0;
                count_d   = CNT_ZERO;
                sat_d     = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_ACCUM;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            acc_hi_q  <= 16'd0;
            acc_lo_q  <= 16'd0;
            count_q   <= CNT_ZERO;
            sat_q     <= 1'b0;
            m_data_q  <= 32'd0;
            m_words_q <= CNT_ZERO;
            m_sat_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
            m_data_q  <= m_data_d;
            m_words_q <= m_words_d;
            m_sat_q   <= m_sat_d;
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_words = m_words_q;
    assign bus.m_sat   = m_sat_q;

endmodule
